// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared control-word layout, stage types and forwarding codes
package ctrl_pkg;

    localparam int CW     = 8;
    localparam int REG_AW = 5;

    localparam int CTL_ALUSRC   = 7;
    localparam int CTL_MEMTOREG = 6;
    localparam int CTL_REGWRITE = 5;
    localparam int CTL_MEMREAD  = 4;
    localparam int CTL_MEMWRITE = 3;
    localparam int CTL_BRANCH   = 2;
    localparam int CTL_ALUOP    = 0;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef struct packed {
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic [1:0] aluop;
    } ctrl_word_t;

    typedef struct packed {
        ctrl_word_t        ctrl;
        logic [REG_AW-1:0] rd;
    } stage_t;

    typedef struct packed {
        ctrl_word_t        ctrl;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
    } ex_stage_t;

    localparam stage_t    STAGE_BUBBLE = '0;
    localparam ex_stage_t EX_BUBBLE    = '0;

endpackage

// File: rtl/ctrl_pipe_if.sv
// rtl/ctrl_pipe_if.sv - ID-side inputs and per-stage control outputs of ctrl_pipe
import ctrl_pkg::*;

interface ctrl_pipe_if;
    logic [CW-1:0]     ctrl_id;
    logic [REG_AW-1:0] rd_id;
    logic [REG_AW-1:0] rs1_id;
    logic [REG_AW-1:0] rs2_id;
    logic              branch_taken;
    logic              freeze;
    logic              stall_id;
    logic              alusrc_ex;
    logic [1:0]        aluop_ex;
    logic              branch_ex;
    logic              memread_mem;
    logic              memwrite_mem;
    logic              memtoreg_wb;
    logic              regwrite_wb;
    logic [REG_AW-1:0] rd_wb;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;

    modport master (
        output ctrl_id, rd_id, rs1_id, rs2_id, branch_taken, freeze,
        input  stall_id, alusrc_ex, aluop_ex, branch_ex, memread_mem, memwrite_mem,
               memtoreg_wb, regwrite_wb, rd_wb, fwd_a, fwd_b
    );

    modport slave (
        input  ctrl_id, rd_id, rs1_id, rs2_id, branch_taken, freeze,
        output stall_id, alusrc_ex, aluop_ex, branch_ex, memread_mem, memwrite_mem,
               memtoreg_wb, regwrite_wb, rd_wb, fwd_a, fwd_b
    );
endinterface

// File: rtl/ctrl_fwd_unit.sv
// rtl/ctrl_fwd_unit.sv - combinational forwarding select for one EX source operand
import ctrl_pkg::*;

module ctrl_fwd_unit (
    input  logic [REG_AW-1:0] src_i,
    input  logic              mem_regwrite_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              wb_regwrite_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    output logic [1:0]        fwd_o
);
    // The younger MEM result wins over WB; x0 is hardwired and never forwards.
    always_comb begin
        fwd_o = FWD_RF;
        if (mem_regwrite_i && (mem_rd_i != '0) && (mem_rd_i == src_i)) begin
            fwd_o = FWD_MEM;
        end else if (wb_regwrite_i && (wb_rd_i != '0) && (wb_rd_i == src_i)) begin
            fwd_o = FWD_WB;
        end
    end
endmodule

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - EX/MEM/WB control pipeline with load-use stall, flush, freeze
import ctrl_pkg::*;

module ctrl_pipe (
    input  logic        clk,
    input  logic        rst,
    ctrl_pipe_if.slave  bus
);
    ex_stage_t ex_q, ex_d;
    stage_t    mem_q, mem_d;
    stage_t    wb_q, wb_d;
    logic      load_use;
    logic      stall;
    logic      unused_ctrl_bits;

    always_comb begin
        ex_d     = ex_q;
        mem_d    = mem_q;
        wb_d     = wb_q;
        stall    = 1'b0;
        load_use = ex_q.ctrl.memread && (ex_q.rd != '0) &&
                   ((ex_q.rd == bus.rs1_id) || (ex_q.rd == bus.rs2_id));
        if (bus.freeze) begin
            stall = 1'b1;
        end else begin
            mem_d.ctrl = ex_q.ctrl;
            mem_d.rd   = ex_q.rd;
            wb_d       = mem_q;
            // A taken branch kills the ID word, so it must not also raise a stall.
            if (bus.branch_taken) begin
                ex_d = EX_BUBBLE;
            end else if (load_use) begin
                ex_d  = EX_BUBBLE;
                stall = 1'b1;
            end else begin
                ex_d.ctrl = ctrl_word_t'(bus.ctrl_id);
                ex_d.rd   = bus.rd_id;
                ex_d.rs1  = bus.rs1_id;
                ex_d.rs2  = bus.rs2_id;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= EX_BUBBLE;
            mem_q <= STAGE_BUBBLE;
            wb_q  <= STAGE_BUBBLE;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign bus.stall_id     = stall;
    assign bus.alusrc_ex    = ex_q.ctrl.alusrc;
    assign bus.aluop_ex     = ex_q.ctrl.aluop;
    assign bus.branch_ex    = ex_q.ctrl.branch;
    assign bus.memread_mem  = mem_q.ctrl.memread;
    assign bus.memwrite_mem = mem_q.ctrl.memwrite;
    assign bus.memtoreg_wb  = wb_q.ctrl.memtoreg;
    assign bus.regwrite_wb  = wb_q.ctrl.regwrite;
    assign bus.rd_wb        = wb_q.rd;

    assign unused_ctrl_bits = ^{ex_q.ctrl, mem_q.ctrl, wb_q.ctrl};

    ctrl_fwd_unit u_fwd_a (
        .src_i          (ex_q.rs1),
        .mem_regwrite_i (mem_q.ctrl.regwrite),
        .mem_rd_i       (mem_q.rd),
        .wb_regwrite_i  (wb_q.ctrl.regwrite),
        .wb_rd_i        (wb_q.rd),
        .fwd_o          (bus.fwd_a)
    );

    ctrl_fwd_unit u_fwd_b (
        .src_i          (ex_q.rs2),
        .mem_regwrite_i (mem_q.ctrl.regwrite),
        .mem_rd_i       (mem_q.rd),
        .wb_regwrite_i  (wb_q.ctrl.regwrite),
        .wb_rd_i        (wb_q.rd),
        .fwd_o          (bus.fwd_b)
    );
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - scoreboard bench for ctrl_pipe
module tb_ctrl_pipe;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;
    int   cyc;

    typedef struct {
        int         due;
        logic       memtoreg;
        logic [4:0] rd;
    } exp_t;
    exp_t sb[$];

    ctrl_pipe_if bus ();

    ctrl_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic expect_wb(input int due, input logic [7:0] c, input logic [4:0] rd);
        exp_t e;
        if (c[5]) begin
            e.due      = due;
            e.memtoreg = c[6];
            e.rd       = rd;
            sb.push_back(e);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("wb_regwrite", bus.regwrite_wb, 1'b1);
            check("wb_memtoreg", bus.memtoreg_wb, e.memtoreg);
            check("wb_rd", bus.rd_wb, e.rd);
        end else begin
            check("wb_idle", bus.regwrite_wb, 1'b0);
        end
    endtask

    task automatic issue(input logic [7:0] c, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2);
        bus.ctrl_id = c;
        bus.rd_id   = rd;
        bus.rs1_id  = rs1;
        bus.rs2_id  = rs2;
    endtask

    task automatic drain();
        issue(8'h00, 5'd0, 5'd0, 5'd0);
        repeat (4) tick();
    endtask

    function automatic logic [31:0] all_outs();
        return {bus.stall_id, bus.alusrc_ex, bus.aluop_ex, bus.branch_ex, bus.memread_mem,
                bus.memwrite_mem, bus.memtoreg_wb, bus.regwrite_wb, bus.rd_wb,
                bus.fwd_a, bus.fwd_b};
    endfunction

    initial begin
        n_checks = 0;
        n_err    = 0;
        cyc      = 0;
        rst      = 1'b1;
        bus.branch_taken = 1'b0;
        bus.freeze       = 1'b0;
        issue(8'h00, 5'd0, 5'd0, 5'd0);
        repeat (2) tick();
        check("reset_outs", all_outs(), 32'd0);
        rst = 1'b0;

        // addi x5 then add rs1=5: MEM forward; with a nop between: WB forward
        issue(8'hA0, 5'd5, 5'd0, 5'd0); expect_wb(cyc + 3, 8'hA0, 5'd5); tick();
        issue(8'h22, 5'd6, 5'd5, 5'd0); expect_wb(cyc + 3, 8'h22, 5'd6); tick();
        check("fwd_a_mem", bus.fwd_a, 2'b10);
        check("fwd_b_rf", bus.fwd_b, 2'b00);
        issue(8'hA0, 5'd5, 5'd0, 5'd0); expect_wb(cyc + 3, 8'hA0, 5'd5); tick();
        issue(8'h00, 5'd0, 5'd0, 5'd0); tick();
        issue(8'h22, 5'd6, 5'd5, 5'd0); expect_wb(cyc + 3, 8'h22, 5'd6); tick();
        check("fwd_a_wb", bus.fwd_a, 2'b01);
        drain();

        // lw x7 then add rs2=7: one-cycle load-use stall
        issue(8'hF0, 5'd7, 5'd0, 5'd0); expect_wb(cyc + 3, 8'hF0, 5'd7); tick();
        issue(8'h22, 5'd8, 5'd1, 5'd7);
        #1 check("lu_stall", bus.stall_id, 1'b1);
        tick();
        check("lu_ex_bubble", {bus.alusrc_ex, bus.aluop_ex, bus.branch_ex}, 4'd0);
        check("lu_mem_load", bus.memread_mem, 1'b1);
        check("lu_stall_clear", bus.stall_id, 1'b0);
        expect_wb(cyc + 3, 8'h22, 5'd8); tick();
        check("lu_ex_add", bus.aluop_ex, 2'b10);
        check("lu_fwd_b_wb", bus.fwd_b, 2'b01);
        check("lu_fwd_a_rf", bus.fwd_a, 2'b00);
        drain();

        // same hazard with a taken branch: flush wins, no stall
        issue(8'hF0, 5'd7, 5'd0, 5'd0); expect_wb(cyc + 3, 8'hF0, 5'd7); tick();
        issue(8'h22, 5'd8, 5'd1, 5'd7);
        bus.branch_taken = 1'b1;
        #1 check("flush_stall", bus.stall_id, 1'b0);
        tick();
        bus.branch_taken = 1'b0;
        issue(8'h00, 5'd0, 5'd0, 5'd0);
        check("flush_ex_bubble", {bus.alusrc_ex, bus.aluop_ex, bus.branch_ex}, 4'd0);
        check("flush_mem_load", bus.memread_mem, 1'b1);
        drain();

        // freeze for 3 cycles with beq in EX and addi x3 in MEM
        issue(8'hA0, 5'd3, 5'd0, 5'd0); expect_wb(cyc + 6, 8'hA0, 5'd3); tick();
        issue(8'h05, 5'd0, 5'd1, 5'd2); tick();
        bus.freeze = 1'b1;
        issue(8'hA0, 5'd9, 5'd0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("frz_stall", bus.stall_id, 1'b1);
            check("frz_branch_ex", bus.branch_ex, 1'b1);
            check("frz_aluop_ex", bus.aluop_ex, 2'b01);
            tick();
        end
        bus.freeze = 1'b0;
        expect_wb(cyc + 3, 8'hA0, 5'd9);
        #1 check("frz_release_stall", bus.stall_id, 1'b0);
        tick();
        check("frz_resume", {bus.alusrc_ex, bus.branch_ex}, 2'b10);
        drain();

        // load into x0 never stalls and never forwards
        issue(8'hF0, 5'd0, 5'd0, 5'd0); expect_wb(cyc + 3, 8'hF0, 5'd0); tick();
        issue(8'h22, 5'd1, 5'd0, 5'd0);
        #1 check("x0_no_stall", bus.stall_id, 1'b0);
        expect_wb(cyc + 3, 8'h22, 5'd1); tick();
        check("x0_fwd_a", bus.fwd_a, 2'b00);
        check("x0_fwd_b", bus.fwd_b, 2'b00);
        drain();

        // asynchronous reset mid-stream, then a fresh word takes 3 cycles to WB
        issue(8'hA0, 5'd10, 5'd0, 5'd0); tick();
        issue(8'hA0, 5'd11, 5'd10, 5'd0); tick();
        check("pre_rst_ex", bus.alusrc_ex, 1'b1);
        check("pre_rst_fwd", bus.fwd_a, 2'b10);
        #2 rst = 1'b1;
        #1 check("rst_async", all_outs(), 32'd0);
        sb.delete();
        tick();
        rst = 1'b0;
        issue(8'hA0, 5'd12, 5'd0, 5'd0); expect_wb(cyc + 3, 8'hA0, 5'd12); tick();
        drain();

        check("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
